// File: rtl/lt24_touch_penirq_filter.sv
// PENIRQ_N conditioning for the LT24 touch controller: two-flop synchronizer,
// ADC-conversion blanking and a debounce FSM with press/release strobes.
module lt24_touch_penirq_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES    = 100,
  parameter int unsigned CNT_W           = 17,
  parameter int unsigned BLANK_W         = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       penirq_n_raw,
  input  logic       adc_busy,
  input  logic       glitch_clr,
  output logic       penirq_n_out,
  output logic       pen_down,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] glitch_count
);

  typedef enum logic [1:0] {
    UP,
    PRESS_QUAL,
    DOWN,
    RELEASE_QUAL
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

  logic               s1;
  logic               s2;
  logic [BLANK_W-1:0] blank_cnt;
  logic               blank;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               glitch_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= penirq_n_raw;
      s2 <= s1;
    end
  end

  // Blanking covers the busy cycles themselves plus a settle tail after busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt <= '0;
    end else if (adc_busy) begin
      blank_cnt <= BLANK_LOAD;
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
    end
  end

  assign blank = adc_busy | (blank_cnt != '0);

  // An abort caused by the pin reverting counts as a glitch; a blanking abort does not.
  always_comb begin
    glitch_inc = 1'b0;
    if (!blank) begin
      if (state == PRESS_QUAL && s2) begin
        glitch_inc = 1'b1;
      end else if (state == RELEASE_QUAL && !s2) begin
        glitch_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= UP;
      cnt           <= '0;
      penirq_n_out  <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        UP: begin
          if (!s2 && !blank) begin
            state <= PRESS_QUAL;
            cnt   <= '0;
          end
        end
        PRESS_QUAL: begin
          if (blank || s2) begin
            state <= UP;
          end else if (cnt == CNT_LAST) begin
            state        <= DOWN;
            penirq_n_out <= 1'b0;
            press_pulse  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (s2 && !blank) begin
            state <= RELEASE_QUAL;
            cnt   <= '0;
          end
        end
        RELEASE_QUAL: begin
          if (blank || !s2) begin
            state <= DOWN;
          end else if (cnt == CNT_LAST) begin
            state         <= UP;
            penirq_n_out  <= 1'b1;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state        <= UP;
          penirq_n_out <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || glitch_clr) begin
      glitch_count <= '0;
    end else if (glitch_inc && glitch_count != 8'hFF) begin
      glitch_count <= glitch_count + 8'd1;
    end
  end

  assign pen_down = ~penirq_n_out;

endmodule

// File: tb/tb_lt24_touch_penirq_filter.sv
// Bench for lt24_touch_penirq_filter: segment table, corner-case sequences and
// random stimulus against a run-length reference model.
module tb_lt24_touch_penirq_filter;

  localparam int D = 8;
  localparam int B = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       penirq_n_raw = 1'b1;
  logic       adc_busy = 1'b0;
  logic       glitch_clr = 1'b0;
  logic       penirq_n_out;
  logic       pen_down;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] glitch_count;

  int errors = 0;
  int checks = 0;
  int n_press = 0;
  int n_rel = 0;

  lt24_touch_penirq_filter #(
    .DEBOUNCE_CYCLES(D),
    .BLANK_CYCLES(B),
    .CNT_W(4),
    .BLANK_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .penirq_n_raw(penirq_n_raw),
    .adc_busy(adc_busy),
    .glitch_clr(glitch_clr),
    .penirq_n_out(penirq_n_out),
    .pen_down(pen_down),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  // Reference model: pin seen two samples late, busy-quiet edge count for
  // blanking, and a run length of disagreeing samples that flips the level at D+1.
  bit          m_s1 = 1'b1, m_s2 = 1'b1;
  int unsigned m_quiet = 1000;
  bit          m_pen_n = 1'b1;
  int unsigned m_run = 0;
  int unsigned m_gl = 0;
  bit          m_press = 1'b0, m_rel = 1'b0;

  task automatic model_edge(input bit raw, input bit busy, input bit clr, input bit rst);
    bit blank;
    bit inc;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_quiet = 1000; m_pen_n = 1'b1;
      m_run = 0; m_gl = 0; m_press = 1'b0; m_rel = 1'b0;
      return;
    end
    blank   = busy || (m_quiet < B);
    inc     = 1'b0;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (blank) begin
      m_run = 0;
    end else if (m_s2 == m_pen_n) begin
      if (m_run > 0) inc = 1'b1;
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == D + 1) begin
        m_pen_n = !m_pen_n;
        if (m_pen_n) m_rel = 1'b1; else m_press = 1'b1;
        m_run = 0;
      end
    end
    if (clr) m_gl = 0;
    else if (inc && m_gl < 255) m_gl++;
    if (busy) m_quiet = 0;
    else if (m_quiet < 1000) m_quiet++;
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit raw, input bit busy, input bit clr, input bit rst);
    logic [11:0] got, want;
    penirq_n_raw = raw;
    adc_busy     = busy;
    glitch_clr   = clr;
    reset        = rst;
    @(posedge clk);
    model_edge(raw, busy, clr, rst);
    #1;
    got  = {penirq_n_out, pen_down, press_pulse, release_pulse, glitch_count};
    want = {m_pen_n, !m_pen_n, m_press, m_rel, 8'(m_gl)};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL model: got pen_n/down/press/rel/gl=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d at %0t",
               got[11], got[10], got[9], got[8], got[7:0],
               want[11], want[10], want[9], want[8], want[7:0], $time);
    end
    if (press_pulse === 1'b1) n_press++;
    if (release_pulse === 1'b1) n_rel++;
  endtask

  task automatic run_until(input bit raw, input bit busy, input bit target,
                           input int max_n, output int at);
    at = 0;
    for (int i = 1; i <= max_n; i++) begin
      tick(raw, busy, 1'b0, 1'b0);
      if (at == 0 && penirq_n_out === target) at = i;
    end
  endtask

  // Two low samples then three high: one aborted press qualification, abort on the 5th edge.
  task automatic abort_pat(input bit clr_on_abort);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, clr_on_abort, 1'b0);
  endtask

  typedef struct packed {
    bit raw;
    bit busy;
    int len;
    bit pen_n;
    bit press;
    bit rel;
    int gl;
  } seg_t;

  seg_t segs[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int at;
    bit stayed;
    bit raw_r, busy_r, clr_r, rst_r;
    int busy_left;

    segs[0]  = '{1'b1, 1'b0, 4,  1'b1, 1'b0, 1'b0, 0};
    segs[1]  = '{1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 0};
    segs[2]  = '{1'b0, 1'b0, 1,  1'b0, 1'b1, 1'b0, 0};
    segs[3]  = '{1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b0, 0};
    segs[4]  = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 0};
    segs[5]  = '{1'b1, 1'b0, 1,  1'b1, 1'b0, 1'b1, 0};
    segs[6]  = '{1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 0};
    segs[7]  = '{1'b0, 1'b0, 8,  1'b1, 1'b0, 1'b0, 0};
    segs[8]  = '{1'b1, 1'b0, 5,  1'b1, 1'b0, 1'b0, 1};
    segs[9]  = '{1'b0, 1'b0, 9,  1'b1, 1'b0, 1'b0, 1};
    segs[10] = '{1'b1, 1'b0, 2,  1'b0, 1'b1, 1'b0, 1};
    segs[11] = '{1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0, 1};

    tick(1'b1, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    check("reset_pen_n", int'(penirq_n_out), 1);
    check("reset_pen_down", int'(pen_down), 0);
    check("reset_press", int'(press_pulse), 0);
    check("reset_release", int'(release_pulse), 0);
    check("reset_glitch", int'(glitch_count), 0);

    // Clean press/release latency, D-long glitch vs D+1-long press.
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < segs[s].len; i++) tick(segs[s].raw, segs[s].busy, 1'b0, 1'b0);
      check($sformatf("seg%0d_pen_n", s), int'(penirq_n_out), int'(segs[s].pen_n));
      check($sformatf("seg%0d_press", s), int'(press_pulse), int'(segs[s].press));
      check($sformatf("seg%0d_release", s), int'(release_pulse), int'(segs[s].rel));
      check($sformatf("seg%0d_glitch", s), int'(glitch_count), segs[s].gl);
    end

    // Bounce: 5 low, 2 high, then held low.
    n_press = 0;
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(1'b0, 1'b0, 1'b0, 20, at);
    check("bounce_latency", at, 11);
    check("bounce_glitch", int'(glitch_count), 2);
    check("bounce_presses", n_press, 1);

    // Busy while DOWN with the pin toggling: no state change.
    n_press = 0; n_rel = 0; stayed = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(bit'(i & 1), 1'b1, 1'b0, 1'b0);
      if (penirq_n_out !== 1'b0) stayed = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      if (penirq_n_out !== 1'b0) stayed = 1'b0;
    end
    check("blank_down_held", int'(stayed), 1);
    check("blank_glitch", int'(glitch_count), 2);
    check("blank_pulses", n_press + n_rel, 0);

    run_until(1'b1, 1'b0, 1'b1, 20, at);
    check("release_latency", at, 11);
    check("release_count", n_rel, 1);

    // Pin low two cycles after busy falls.
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run_until(1'b0, 1'b0, 1'b0, 20, at);
    check("blank_late_press", at, 11);
    run_until(1'b1, 1'b0, 1'b1, 20, at);
    check("release_latency2", at, 11);

    // Pin already low during busy: qualification held off until the tail expires.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1'b0);
    run_until(1'b0, 1'b0, 1'b0, 20, at);
    check("blank_tail_press", at, 13);
    run_until(1'b1, 1'b0, 1'b1, 20, at);
    check("release_latency3", at, 11);

    for (int i = 0; i < 300; i++) abort_pat(1'b0);
    check("glitch_saturated", int'(glitch_count), 255);
    abort_pat(1'b1);
    check("glitch_clr_wins", int'(glitch_count), 0);
    abort_pat(1'b0);
    check("glitch_after_clr", int'(glitch_count), 1);

    // Reset at cnt=5 of press qualification.
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("midreset_pen_n", int'(penirq_n_out), 1);
    check("midreset_pen_down", int'(pen_down), 0);
    check("midreset_pulses", int'(press_pulse) + int'(release_pulse), 0);
    check("midreset_glitch", int'(glitch_count), 0);
    n_press = 0;
    run_until(1'b0, 1'b0, 1'b0, 20, at);
    check("midreset_press_latency", at, 11);
    check("midreset_presses", n_press, 1);

    raw_r = 1'b1;
    busy_left = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0) raw_r = !raw_r;
      if (busy_left > 0) begin
        busy_r = 1'b1;
        busy_left--;
      end else begin
        busy_r = 1'b0;
        if ($urandom_range(59) == 0) busy_left = int'($urandom_range(6, 1));
      end
      clr_r = ($urandom_range(199) == 0);
      rst_r = ($urandom_range(999) == 0);
      tick(raw_r, busy_r, clr_r, rst_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt24_touch_penirq_filter.md
# lt24_touch_penirq_filter

Conditions the raw active-low PENIRQ_N pin from the LT24 touch controller before it reaches the touch pen-IRQ PIO input port. It provides:

- a two-flop synchronizer;
- a debounce/qualification state machine;
- a blanking window that suppresses the false pen-down pulses the touch ADC produces while a conversion is running.

Its clean active-low output drives the PIO `in_port`. Its press/release strobes and glitch counter are available to the touch SPI sampler and to debug logic.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a level change (1 ms at 50 MHz). Must be ≥ 1.
- `BLANK_CYCLES`, default 100: settle cycles of blanking after `adc_busy` falls. 0 means blanking lasts only while `adc_busy` is high.
- `CNT_W`, default 17: width of the debounce counter. Must satisfy 2^CNT_W ≥ `DEBOUNCE_CYCLES`.
- `BLANK_W`, default 8: width of the blanking counter. Must satisfy 2^BLANK_W > `BLANK_CYCLES`.

Ports:
- `clk` — in, 1 — single clock for all logic.
- `reset` — in, 1 — synchronous, active-high.
- `penirq_n_raw` — in, 1 — asynchronous pin from the touch controller; 0 means pen down.
- `adc_busy` — in, 1 — high while the touch SPI sampler is converting.
- `glitch_clr` — in, 1 — one-cycle pulse that clears `glitch_count`.
- `penirq_n_out` — out, 1 — debounced active-low pen state; drives the PIO `in_port`.
- `pen_down` — out, 1 — active-high copy of the debounced state (`~penirq_n_out`).
- `press_pulse` — out, 1 — one-cycle strobe when DOWN is entered.
- `release_pulse` — out, 1 — one-cycle strobe when UP is entered.
- `glitch_count` — out, 8 — saturating count of aborted qualifications.

## Operation
- **Synchronizer:** `s1 <= penirq_n_raw`, then `s2 <= s1`. Both reset to 1. The FSM uses only `s2`.
- **Blanking:**
  - `blank_cnt` loads `BLANK_CYCLES` every cycle that `adc_busy` = 1.
  - Otherwise it decrements toward 0 and stops there.
  - `blank` = `adc_busy` | (`blank_cnt` != 0).
  - Reset value of `blank_cnt` is 0.
- **FSM states:** UP, PRESS_QUAL, DOWN, RELEASE_QUAL. Reset state is UP with `cnt` = 0.
- **UP:**
  - If `s2` = 0 and not `blank`: go to PRESS_QUAL with `cnt` = 0.
  - Otherwise stay in UP.
- **PRESS_QUAL:**
  - If `blank` is active: go to UP with no glitch increment. Blanking takes priority.
  - Else if `s2` = 1: go to UP and increment `glitch_count`.
  - Else if `cnt` = `DEBOUNCE_CYCLES`−1: go to DOWN.
  - Otherwise `cnt` increments.
- **DOWN:**
  - If `s2` = 1 and not `blank`: go to RELEASE_QUAL with `cnt` = 0.
- **RELEASE_QUAL:** mirror of PRESS_QUAL with levels swapped.
  - `blank` → DOWN, no increment.
  - `s2` = 0 → DOWN, increment `glitch_count`.
  - `cnt` = `DEBOUNCE_CYCLES`−1 → UP.
- **Outputs:** all registered.
  - `penirq_n_out` = 0 exactly when the state is DOWN or RELEASE_QUAL.
  - `press_pulse` is high for the single cycle after the edge that enters DOWN from PRESS_QUAL.
  - `release_pulse` is high for the single cycle after the edge that enters UP from RELEASE_QUAL.
  - An abort back to the prior stable state produces no pulse.
- **`glitch_count`:**
  - Saturates at 255.
  - If `glitch_clr` and an increment occur in the same cycle, the clear wins and the result is 0.
- **Reset values:** `penirq_n_out` = 1, `pen_down` = 0, `press_pulse` = 0, `release_pulse` = 0, `glitch_count` = 0.
- **Reset mid-qualification:** returns to UP with no pulse. The synchronizer is reloaded to 1.

## Timing
- **Press latency:** numbering from the first clock edge that samples `penirq_n_raw` = 0, with the pin held low and no blanking:
  - `s2` = 0 after edge 2;
  - PRESS_QUAL is entered at edge 3;
  - DOWN is entered and `penirq_n_out` falls at edge `DEBOUNCE_CYCLES`+3;
  - `press_pulse` is high during the following cycle.
- **Release latency:** identical, `DEBOUNCE_CYCLES`+3 edges.
- **Glitch length:** a low pulse on the pin shorter than `DEBOUNCE_CYCLES`+1 cycles never changes `penirq_n_out`.
- **Blanking window:**
  - Active from the cycle `adc_busy` is sampled high.
  - Ends `BLANK_CYCLES` edges after the first edge that samples `adc_busy` = 0.
- **Pulse spacing:** `press_pulse` and `release_pulse` are never high in the same cycle. The minimum spacing between them is `DEBOUNCE_CYCLES`+1 cycles.
- **Throughput:** no stalls. One FSM decision is made per cycle.

## Test plan
Run with `DEBOUNCE_CYCLES` = 8 and `BLANK_CYCLES` = 4.
1. **Clean press:** drive `penirq_n_raw` low at edge 0 and hold it.
   - Expected: `penirq_n_out` falls at edge 11.
   - Expected: `press_pulse` is high for exactly 1 cycle.
   - Expected: `glitch_count` stays 0.
2. **Bounce:** drive the pin low for 5 cycles, high for 2, then low and hold.
   - Expected: `glitch_count` = 1.
   - Expected: DOWN is reached 11 edges after the final fall.
   - Expected: exactly one `press_pulse`.
3. **Blanking:**
   - While DOWN, pulse `adc_busy` for 10 cycles while the pin toggles high and low. Expected: no state change and `glitch_count` unchanged.
   - Drive the pin low 2 cycles after `adc_busy` falls. Expected: qualification starts no earlier than the 4th cycle after the fall.
4. **Release and saturation:**
   - Release from DOWN with a clean high. Expected: `release_pulse` at +11 edges.
   - Force 300 aborts. Expected: `glitch_count` = 255.
   - Pulse `glitch_clr` in the same cycle as an abort. Expected: `glitch_count` = 0.
5. **Reset mid-qualification:** assert `reset` for 1 cycle at cnt = 5 of PRESS_QUAL.
   - Expected on the next cycle: `penirq_n_out` = 1, `pen_down` = 0, no pulses, `glitch_count` = 0.
   - Expected: with the pin still low, a fresh press completes 11 edges after reset deasserts.
